config_bank: RTL and testbench

Parametrised, multi-word configuration register bank; successor to the single-byte config cell. Holds DEPTH words of WIDTH bits as a writable shadow copy plus an atomically committed active copy, with addressed readback, a sticky write lock and a saturating TMR-mismatch counter. Sits between the slow-control interface and the datapath. `active_cfg` drives the datapath and changes only on commit. Intended for default triplication, with voted feedback on every storage register.

---
 rtl/config_bank_pkg.sv | 19 +
 rtl/config_word.sv | 29 ++
 rtl/config_bank.sv | 89 ++++++++
 tb/tb_config_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/config_bank_pkg.sv
// config_bank shared constants and helpers.
// Bank select encoding and error counter width.
package config_bank_pkg;

  localparam int ERR_CNT_W = 8;

  localparam logic BANK_SHADOW = 1'b0;
  localparam logic BANK_ACTIVE = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/config_word.sv
// One configuration word: writable shadow plus committed active copy.
// Both registers hold their own value when not loaded.
module config_word
  import config_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RV = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] active
);

  // active samples the pre-write shadow
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow <= RV;
      active <= RV;
    end else begin
      shadow <= we ? wdata : shadow;
      active <= commit ? shadow : active;
    end
  end

endmodule

// File: rtl/config_bank.sv
// Multi-word config bank: shadow/active words, readback,
// sticky write lock and saturating TMR mismatch counter.
module config_bank
  import config_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [DEPTH*WIDTH-1:0] RESET_VALUE = '0,
  localparam int AW =
    (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [AW:0]            addr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid,
  output logic                   rerr,
  input  logic                   commit,
  input  logic                   lock_set,
  output logic                   locked,
  input  logic                   err_in,
  output logic [ERR_CNT_W-1:0]   err_count,
  input  logic                   err_clr,
  output logic [DEPTH*WIDTH-1:0] active_cfg
);

  logic [AW-1:0]    idx;
  logic             bank;
  logic             in_rng;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] sh [DEPTH];
  logic [WIDTH-1:0] ac [DEPTH];

  assign idx    = addr[AW-1:0];
  assign bank   = addr[AW];
  assign in_rng = {1'b0, idx} < (AW+1)'(DEPTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic we;
    assign we = wr_en & ~locked & (idx == AW'(i));

    config_word #(
      .WIDTH (WIDTH),
      .RV    (RESET_VALUE[i*WIDTH +: WIDTH])
    ) u_word (
      .clk    (clk),
      .rstn   (rstn),
      .we     (we),
      .wdata  (wdata),
      .commit (commit),
      .shadow (sh[i]),
      .active (ac[i])
    );

    assign active_cfg[i*WIDTH +: WIDTH] = ac[i];
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == AW'(i))
        sel = (bank == BANK_SHADOW) ? sh[i] : ac[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      rerr      <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      rvalid <= rd_en;
      rerr   <= rd_en & ~in_rng;
      if (rd_en) rdata <= in_rng ? sel : '0;
      locked <= locked | lock_set;
      // clear wins over a coincident mismatch
      if (err_clr)
        err_count <= '0;
      else if (err_in && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_config_bank.sv
// Self-checking bench for config_bank: vector table,
// directed corner sequences and a randomized model run.
module tb_config_bank;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en, rd_en, commit, lock_set;
  logic        err_in, err_clr;
  logic [2:0]  addr;
  logic [7:0]  wdata, rdata, err_count;
  logic        rvalid, rerr, locked;
  logic [31:0] active_cfg;

  logic        wr_b, rd_b, cm_b;
  logic [2:0]  addr_b;
  logic [7:0]  wd_b, rdata_b, cnt_b;
  logic        rvalid_b, rerr_b, locked_b;
  logic [23:0] cfg_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  config_bank #(
    .WIDTH(8), .DEPTH(4), .RESET_VALUE(32'h44332211)
  ) u0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rd_en(rd_en), .rdata(rdata),
    .rvalid(rvalid), .rerr(rerr), .commit(commit),
    .lock_set(lock_set), .locked(locked), .err_in(err_in),
    .err_count(err_count), .err_clr(err_clr),
    .active_cfg(active_cfg)
  );

  config_bank #(
    .WIDTH(8), .DEPTH(3), .RESET_VALUE(24'h030201)
  ) u1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_b), .addr(addr_b),
    .wdata(wd_b), .rd_en(rd_b), .rdata(rdata_b),
    .rvalid(rvalid_b), .rerr(rerr_b), .commit(cm_b),
    .lock_set(1'b0), .locked(locked_b), .err_in(1'b0),
    .err_count(cnt_b), .err_clr(1'b0), .active_cfg(cfg_b)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; commit = 0; lock_set = 0;
    err_in = 0; err_clr = 0; addr = '0; wdata = '0;
    wr_b = 0; rd_b = 0; cm_b = 0; addr_b = '0; wd_b = '0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [7:0]  wd;
    logic        rd;
    logic        cm;
    logic [7:0]  e_rdata;
    logic        e_rvalid;
    logic [31:0] e_cfg;
  } vec_t;

  vec_t vt [11];

  // reference model state
  logic [7:0] msh [4];
  logic [7:0] mac [4];
  logic       mlk, mrv;
  logic [7:0] mrd;
  int         mcnt;

  initial begin
    vt[0]  = '{0, 3'd2, 8'h00, 1, 0, 8'h33, 1, 32'h44332211};
    vt[1]  = '{1, 3'd1, 8'hA5, 0, 0, 8'h33, 0, 32'h44332211};
    vt[2]  = '{0, 3'd1, 8'h00, 1, 0, 8'hA5, 1, 32'h44332211};
    vt[3]  = '{0, 3'd5, 8'h00, 1, 0, 8'h22, 1, 32'h44332211};
    vt[4]  = '{0, 3'd0, 8'h00, 0, 1, 8'h22, 0, 32'h4433A511};
    vt[5]  = '{1, 3'd0, 8'h5A, 0, 1, 8'h22, 0, 32'h4433A511};
    vt[6]  = '{0, 3'd4, 8'h00, 1, 0, 8'h11, 1, 32'h4433A511};
    vt[7]  = '{0, 3'd0, 8'h00, 0, 1, 8'h11, 0, 32'h4433A55A};
    vt[8]  = '{0, 3'd4, 8'h00, 1, 0, 8'h5A, 1, 32'h4433A55A};
    vt[9]  = '{1, 3'd2, 8'h77, 1, 0, 8'h33, 1, 32'h4433A55A};
    vt[10] = '{0, 3'd2, 8'h00, 1, 0, 8'h77, 1, 32'h4433A55A};

    idle();
    rstn = 0;
    tick();
    rstn = 1;
    chk("rst_cfg", active_cfg, 32'h44332211);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_errcnt", {24'd0, err_count}, 0);
    chk("rst_cfg_b", {8'd0, cfg_b}, 32'h030201);

    foreach (vt[i]) begin
      wr_en = vt[i].wr; addr = vt[i].a; wdata = vt[i].wd;
      rd_en = vt[i].rd; commit = vt[i].cm;
      tick();
      chk($sformatf("vec%0d_rvalid", i), {31'd0, rvalid},
          {31'd0, vt[i].e_rvalid});
      chk($sformatf("vec%0d_rdata", i), {24'd0, rdata},
          {24'd0, vt[i].e_rdata});
      chk($sformatf("vec%0d_cfg", i), active_cfg, vt[i].e_cfg);
    end
    idle();
    tick();
    chk("rvalid_drop", {31'd0, rvalid}, 0);
    chk("rdata_hold", {24'd0, rdata}, 32'h77);

    // out-of-range on DEPTH=3
    rd_b = 1; addr_b = 3'd3; wr_b = 1; wd_b = 8'hEE;
    tick();
    chk("oor_rerr", {31'd0, rerr_b}, 1);
    chk("oor_rdata", {24'd0, rdata_b}, 0);
    chk("oor_rvalid", {31'd0, rvalid_b}, 1);
    wr_b = 0; addr_b = 3'd7; cm_b = 1;
    tick();
    chk("oor_act_rerr", {31'd0, rerr_b}, 1);
    chk("oor_cfg", {8'd0, cfg_b}, 32'h030201);
    for (int i = 0; i < 3; i++) begin
      cm_b = 0; addr_b = 3'(i);
      tick();
      chk("oor_nochg", {24'd0, rdata_b}, 32'(i + 1));
      chk("inr_rerr", {31'd0, rerr_b}, 0);
    end
    idle();

    // lock: same-cycle write still lands
    wr_en = 1; addr = 3'd3; wdata = 8'h99; lock_set = 1;
    tick();
    chk("locked", {31'd0, locked}, 1);
    lock_set = 0; addr = 3'd0; wdata = 8'hFF;
    tick();
    wr_en = 0; rd_en = 1; addr = 3'd0;
    tick();
    chk("lock_drop", {24'd0, rdata}, 32'h5A);
    rd_en = 0; commit = 1;
    tick();
    chk("lock_commit", active_cfg, 32'h9977A55A);
    chk("lock_sticky", {31'd0, locked}, 1);
    idle();

    // error counter
    err_in = 1;
    tick();
    chk("err_one", {24'd0, err_count}, 1);
    for (int i = 0; i < 299; i++) tick();
    chk("err_sat", {24'd0, err_count}, 255);
    err_clr = 1;
    tick();
    chk("err_clr_prio", {24'd0, err_count}, 0);
    idle();

    // reset mid-read
    rd_en = 1; addr = 3'd1; rstn = 0;
    tick();
    rstn = 1; rd_en = 0;
    chk("midrst_rvalid", {31'd0, rvalid}, 0);
    chk("midrst_cfg", active_cfg, 32'h44332211);
    chk("midrst_locked", {31'd0, locked}, 0);
    chk("midrst_sh", {24'd0, rdata}, 0);

    for (int i = 0; i < 4; i++) begin
      msh[i] = 8'((32'h44332211 >> (8 * i)) & 32'hFF);
      mac[i] = msh[i];
    end
    mlk = 0; mrv = 0; mrd = 0; mcnt = 0;

    for (int n = 0; n < 600; n++) begin
      logic [1:0] ix;
      wr_en    = 1'($urandom_range(0, 1));
      addr     = 3'($urandom);
      wdata    = 8'($urandom);
      rd_en    = 1'($urandom_range(0, 1));
      commit   = ($urandom_range(0, 3) == 0);
      lock_set = ($urandom_range(0, 199) == 0);
      err_in   = ($urandom_range(0, 2) != 0);
      err_clr  = ($urandom_range(0, 63) == 0);
      ix = addr[1:0];
      mrv = rd_en;
      if (rd_en) mrd = addr[2] ? mac[ix] : msh[ix];
      if (commit) mac = msh;
      if (wr_en && !mlk) msh[ix] = wdata;
      mlk = mlk | lock_set;
      if (err_clr) mcnt = 0;
      else if (err_in) mcnt = (mcnt >= 255) ? 255 : mcnt + 1;
      tick();
      chk("rnd_rvalid", {31'd0, rvalid}, {31'd0, mrv});
      chk("rnd_rdata", {24'd0, rdata}, {24'd0, mrd});
      chk("rnd_rerr", {31'd0, rerr}, 0);
      chk("rnd_cfg", active_cfg,
          {mac[3], mac[2], mac[1], mac[0]});
      chk("rnd_locked", {31'd0, locked}, {31'd0, mlk});
      chk("rnd_errcnt", {24'd0, err_count}, mcnt);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
